uart_rx_fifo: RTL and testbench

Receive-side byte buffer between the UART receiver and the RAM/I/O address decoder. It completes the receiver's go/data-ready handshake on every received byte and stores the byte in a circular FIFO. The decoder then pops bytes at CPU pace, so back-to-back serial input is not lost while the CPU is stalled on cache misses. Bytes that arrive while the FIFO is full are dropped and flagged.

---
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO.
// Acks every UART byte; drops and flags bytes that arrive when full.
module uart_rx_fifo #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_dr,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_go,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [DEPTH_BITWIDTH:0] count,
  output logic                    overflow,
  input  logic                    overflow_clear
);

  localparam int DEPTH = 1 << DEPTH_BITWIDTH;
  localparam logic [DEPTH_BITWIDTH:0] DEPTH_C =
    (DEPTH_BITWIDTH+1)'(DEPTH);
  localparam logic [DEPTH_BITWIDTH:0] ONE_C =
    (DEPTH_BITWIDTH+1)'(1);
  localparam logic [DEPTH_BITWIDTH-1:0] PTR_ONE =
    DEPTH_BITWIDTH'(1);

  typedef enum logic {
    RECEIVE = 1'b0,
    ACK     = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_BITWIDTH-1:0] wr_ptr;
  logic [DEPTH_BITWIDTH-1:0] rd_ptr;

  logic capture;
  logic push;
  logic pop;
  logic drop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A full FIFO still accepts if the same-cycle pop frees a slot
  assign capture = (state == RECEIVE) && rx_dr;
  assign pop     = rd_en && !empty;
  assign push    = capture && (!full || rd_en);
  assign drop    = capture && !push;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Receive handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RECEIVE;
    else        state <= state_nx;
  end

  // Next state and rx_go; ACK holds until rx_dr drops
  always_comb begin
    state_nx = state;
    rx_go    = 1'b0;
    unique case (state)
      RECEIVE: begin
        rx_go = 1'b1;
        if (rx_dr) state_nx = ACK;
      end
      ACK: begin
        if (!rx_dr) state_nx = RECEIVE;
      end
      default: state_nx = RECEIVE;
    endcase
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + ONE_C;
      else if (pop && !push) count <= count - ONE_C;
    end
  end

  // Sticky drop flag; a drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (overflow_clear) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue model checked every cycle,
// plus directed literal expectations.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dr;
  logic [7:0] rx_data;
  logic       rx_go;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       overflow_clear;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.DEPTH_BITWIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_dr(rx_dr),
    .rx_data(rx_data),
    .rx_go(rx_go),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: byte queue, armed flag, sticky flag
  logic [7:0] q[$];
  logic       m_armed;
  logic       m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_armed <= 1'b1;
      m_ovf   <= 1'b0;
    end else begin
      int sz0;
      logic take;
      logic room;
      sz0  = q.size();
      take = m_armed && rx_dr;
      room = (sz0 < 16) || rd_en;
      if (rd_en && sz0 > 0) void'(q.pop_front());
      if (take && room) q.push_back(rx_data);
      if (take && !room)       m_ovf <= 1'b1;
      else if (overflow_clear) m_ovf <= 1'b0;
      if (take)                     m_armed <= 1'b0;
      else if (!m_armed && !rx_dr)  m_armed <= 1'b1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_rx_go", 32'(rx_go), 32'(m_armed));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == 16));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_rd_data", 32'(rd_data),
          32'(q.size() > 0 ? q[0] : 8'h00));
    end
  end

  task automatic step(input logic dr, input logic [7:0] d,
                      input logic re, input logic clr);
    rx_dr          = dr;
    rx_data        = d;
    rd_en          = re;
    overflow_clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    idle();
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_dr = 1'b0;
    rx_data = 8'h00;
    rd_en = 1'b0;
    overflow_clear = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_rx_go", 32'(rx_go), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    idle();

    // single byte
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("one_rx_go", 32'(rx_go), 32'd0);
    chk("one_count", 32'(count), 32'd1);
    chk("one_empty", 32'(empty), 32'd0);
    chk("one_data", 32'(rd_data), 32'h41);
    idle();
    chk("one_rearm", 32'(rx_go), 32'd1);
    pop();
    chk("one_pop_empty", 32'(empty), 32'd1);
    chk("one_pop_data", 32'(rd_data), 32'h0);

    // fill and overflow
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_rx_go", 32'(rx_go), 32'd0);
    idle();
    for (int i = 0; i < 16; i++) begin
      chk("fill_order", 32'(rd_data), 32'(i));
      pop();
    end
    chk("fill_drained", 32'(empty), 32'd1);

    // wrap-around
    for (int i = 0; i < 10; i++) send(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      chk("wrap_a", 32'(rd_data), 32'(8'h20 + i));
      pop();
    end
    for (int i = 0; i < 12; i++) send(8'(8'h30 + i));
    chk("wrap_count", 32'(count), 32'd12);
    for (int i = 0; i < 4; i++) send(8'(8'h3C + i));
    chk("wrap_full", 32'(full), 32'd1);

    // push and pop while full
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_full_count", 32'(count), 32'd16);
    chk("sim_full_head", 32'(rd_data), 32'h31);
    chk("sim_full_ovf", 32'(overflow), 32'd1);
    idle();
    for (int i = 0; i < 15; i++) begin
      chk("sim_order", 32'(rd_data), 32'(8'h31 + i));
      pop();
    end
    chk("sim_last", 32'(rd_data), 32'h55);
    pop();

    // push and pop while empty
    step(1'b1, 8'h66, 1'b1, 1'b0);
    chk("sim_empty_count", 32'(count), 32'd1);
    chk("sim_empty_data", 32'(rd_data), 32'h66);
    idle();
    pop();

    // held rx_dr
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("hold_rx_go", 32'(rx_go), 32'd0);
    end
    chk("hold_count", 32'(count), 32'd1);
    idle();
    chk("hold_rearm", 32'(rx_go), 32'd1);
    pop();

    // overflow clear against drop
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    send(8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // async reset mid-fill
    for (int i = 0; i < 4; i++) pop();
    send(8'hC1);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_rx_go", 32'(rx_go), 32'd1);
    chk("arst_data", 32'(rd_data), 32'h0);
    rx_dr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    send(8'h5A);
    chk("post_rst_data", 32'(rd_data), 32'h5A);
    chk("post_rst_count", 32'(count), 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
